// File: rtl/therm_pkg.sv
// Shared types and sizing helper for the thermometer slew encoder.
package therm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  // Level counter must hold 0..dw inclusive.
  function automatic int therm_cnt_w(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/therm.sv
// Combinational legality check: high when code is a thermometer code (low bits 1, rest 0).
module therm #(
  parameter int W = 8
) (
  input  logic [W-1:0] code,
  output logic         isThermometer
);

  logic [W-1:0] w_inc;

  // A thermometer code plus one has no bits in common with the code; all-ones wraps to zero.
  assign w_inc         = code + W'(1);
  assign isThermometer = ((code & w_inc) == '0);

endmodule

// File: rtl/therm_slew_enc.sv
// Thermometer-code slew encoder: moves codeOut one bit per clock toward a requested level.
// state | meaning
// IDLE  | holding level, ready to accept a new target
// UP    | adding one bit per clock until level reaches target
// DOWN  | removing one bit per clock until level reaches target
module therm_slew_enc
  import therm_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  localparam int CNT_W      = therm_cnt_w(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CNT_W-1:0]      in_level,
  output logic [DATA_WIDTH-1:0] codeOut,
  output logic [CNT_W-1:0]      level_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [CNT_W-1:0] MAX_LVL = CNT_W'(DATA_WIDTH);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_code;
  logic [CNT_W-1:0]      r_level;
  logic [CNT_W-1:0]      r_target;
  logic                  r_done;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_over;
  logic [CNT_W-1:0]      w_target;
  logic [CNT_W-1:0]      w_level_inc;
  logic [CNT_W-1:0]      w_level_dec;

  assign w_accept    = in_valid && (r_state == IDLE);
  assign w_over      = (in_level > MAX_LVL);
  assign w_target    = w_over ? MAX_LVL : in_level;
  assign w_level_inc = r_level + 1'b1;
  assign w_level_dec = r_level - 1'b1;

  // Target is clamped, so UP can never start at full scale nor DOWN at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_code   <= '0;
      r_level  <= '0;
      r_target <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_target <= w_target;
            r_err    <= w_over;
            if (w_target > r_level) begin
              r_state <= UP;
            end else if (w_target < r_level) begin
              r_state <= DOWN;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        UP: begin
          r_code  <= {r_code[DATA_WIDTH-2:0], 1'b1};
          r_level <= w_level_inc;
          if (w_level_inc == r_target) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        DOWN: begin
          r_code  <= {1'b0, r_code[DATA_WIDTH-1:1]};
          r_level <= w_level_dec;
          if (w_level_dec == r_target) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign codeOut   = r_code;
  assign level_out = r_level;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: doc/therm_slew_enc.md
THERM_SLEW_ENC -- requirements
Module: therm_slew_enc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of the thermometer output code.
REQ-002 SHALL derive localparam CNT_W = $clog2(DATA_WIDTH+1), which is 4 at the default.
REQ-003 clk  input  1  single clock; all logic samples on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  a target level is presented.
REQ-006 in_ready  output  1  the block accepts a target this cycle.
REQ-007 in_level  input  CNT_W  requested level (number of ones).
REQ-008 codeOut  output  DATA_WIDTH  registered thermometer code; the low level_out bits are 1, all others 0.
REQ-009 level_out  output  CNT_W  current level, always equal to popcount(codeOut).
REQ-010 busy  output  1  high while stepping toward a target.
REQ-011 done  output  1  one-cycle pulse: the target has been reached.
REQ-012 err  output  1  one-cycle pulse: the accepted in_level exceeded DATA_WIDTH and was clamped.

Function
REQ-013 SHALL implement an FSM with three states: IDLE, UP and DOWN.
REQ-014 in_ready SHALL equal (state==IDLE); accept means in_valid && in_ready at a rising edge.
REQ-015 On accept, target SHALL be min(in_level, DATA_WIDTH); err SHALL pulse in the following cycle when in_level > DATA_WIDTH.
REQ-016 On accept, the next state SHALL be:
  - UP if target > level_out;
  - DOWN if target < level_out;
  - otherwise IDLE, with done pulsed in the following cycle.
REQ-017 In UP, each edge SHALL shift codeOut left by one bit with 1 entering bit 0, and increment level_out.
REQ-018 In DOWN, each edge SHALL shift codeOut right by one bit with 0 entering the MSB, and decrement level_out.
REQ-019 On the edge at which level_out becomes target:
  - the state SHALL return to IDLE;
  - done SHALL be high for exactly the following cycle.
REQ-020 Latency: for distance d = |target - level_out at accept| with acceptance at edge k, codeOut changes at edges k+1..k+d and done is high after edge max(k+d, k).
REQ-021 in_ready SHALL be high in the same cycle as done, so back-to-back accepts are allowed with no idle cycle.
REQ-022 in_valid while busy SHALL be ignored; in_level is not sampled and the upstream holds its request.
REQ-023 codeOut SHALL be a legal thermometer code in every cycle, including the all-zeros and all-ones codes.
REQ-024 Saturation: UP SHALL never be entered at level DATA_WIDTH, and DOWN SHALL never be entered at level 0.
REQ-025 busy SHALL equal (state != IDLE).
REQ-026 done and err SHALL be registered and never high for two consecutive cycles from a single accept.

Reset
REQ-027 With rst_n low at a rising edge, the block SHALL reset to: state IDLE, codeOut 0, level_out 0, target 0, busy 0, done 0, err 0.
REQ-028 in_ready SHALL read 1 after reset.
REQ-029 Reset during UP or DOWN SHALL abandon the target with no done pulse, and the outputs SHALL return to their reset values at that edge.
REQ-030 Reset SHALL take priority over an accept occurring on the same edge.

Structure
REQ-031 The state enum typedef (IDLE/UP/DOWN) SHALL be placed in the shared package therm_pkg.
REQ-032 The CNT_W computation helper SHALL also be placed in therm_pkg.
REQ-033 The RTL SHALL contain no sub-module; the bench SHALL instantiate the existing checker module therm on codeOut and require isThermometer==1 every cycle.

Verification
REQ-034 Ramp up: reset, then accept in_level=4 -> codeOut reads 0000_0001, 0000_0011, 0000_0111, 0000_1111 on consecutive cycles; done pulses once; level_out=4.
REQ-035 Ramp down: from level 8 (1111_1111), accept in_level=1 -> 7 steps down to 0000_0001; busy high for 7 cycles; done pulses once.
REQ-036 Zero distance: at level 4, accept 4 -> codeOut unchanged; done pulses the next cycle; busy stays 0.
REQ-037 Clamp: accept in_level=12 at DATA_WIDTH=8 -> err pulses once; codeOut ramps to 1111_1111; level_out=8.
REQ-038 Ignored request and back-to-back accept: while busy toward level 6, assert in_valid with in_level=0 -> in_level ignored and the level-6 ramp continues; in the done cycle, accept 2 -> DOWN begins on the next edge.
REQ-039 Reset mid-ramp: assert rst_n=0 after codeOut reaches 0000_0111 while going to level 8 -> next edge gives codeOut 0, level_out 0, no done pulse; in_ready reads 1.
